// File: rtl/beep_pkg.sv
// Shared types and constants for the beep sequencer: FSM states, note-table entry layout, end marker.
package beep_pkg;

  localparam int unsigned NOTE_W   = 4;
  localparam int unsigned ENTRY_W  = 3 * NOTE_W;
  localparam int unsigned ACK_WAIT = 3;  // WAIT_ACK cycles before start is re-issued
  localparam logic [NOTE_W-1:0] END_MARKER = '0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] level;
    logic [NOTE_W-1:0] high;
    logic [NOTE_W-1:0] long;
  } note_entry_t;

endpackage

// File: rtl/song_rom.sv
// Note table with a registered 12-bit entry output (one-cycle read latency).
module song_rom
  import beep_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output note_entry_t   data
);

  // Unlisted addresses read as end markers.
  always_ff @(posedge clk) begin
    case (addr)
      AW'(0):  data <= '{level: 4'd1, high: 4'd5, long: 4'd4};
      AW'(1):  data <= '{level: 4'd1, high: 4'd3, long: 4'd4};
      default: data <= '{level: 4'd0, high: 4'd0, long: END_MARKER};
    endcase
  end

endmodule

// File: rtl/beep_sequencer.sv
// Steps through song_rom, handing each note to the note driver and timing a silent gap between notes.
// Define SONG_LOOP_EN to wrap back to entry 0 instead of stopping at the end of the song.
module beep_sequencer
  import beep_pkg::*;
#(
  parameter int unsigned CLK_FRE  = 50,
  parameter int unsigned GAP_MS   = 10,
  parameter int unsigned SONG_LEN = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        play,
  input  logic                        stop,
  input  logic                        done,
  output logic                        start,
  output logic [NOTE_W-1:0]           high,
  output logic [NOTE_W-1:0]           long,
  output logic [NOTE_W-1:0]           level,
  output logic                        busy,
  output logic [$clog2(SONG_LEN)-1:0] note_idx
);

  localparam int unsigned IDX_W  = $clog2(SONG_LEN);
  localparam int unsigned GAP_US = GAP_MS * 1000;
  localparam int unsigned PRE_W  = $clog2(CLK_FRE + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_US + 1);
  localparam int unsigned ACK_W  = $clog2(ACK_WAIT + 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_d;
  logic [NOTE_W-1:0] high_d, long_d, level_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ACK_W-1:0]  ack_q, ack_d;
  logic              retry_q, retry_d;
  logic              start_d, busy_d;
  note_entry_t       rom_q;

  // ROM is addressed with the next index so its output matches note_idx in LOAD.
  song_rom #(.DEPTH(SONG_LEN), .AW(IDX_W)) u_rom (
    .clk  (clk),
    .addr (idx_d),
    .data (rom_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      start    <= 1'b0;
      busy     <= 1'b0;
      high     <= '0;
      long     <= NOTE_W'(1);
      level    <= '0;
      note_idx <= '0;
      presc_q  <= '0;
      gap_q    <= '0;
      ack_q    <= '0;
      retry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      start    <= start_d;
      busy     <= busy_d;
      high     <= high_d;
      long     <= long_d;
      level    <= level_d;
      note_idx <= idx_d;
      presc_q  <= presc_d;
      gap_q    <= gap_d;
      ack_q    <= ack_d;
      retry_q  <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = note_idx;
    high_d  = high;
    long_d  = long;
    level_d = level;
    presc_d = '0;
    gap_d   = '0;
    ack_d   = ack_q;
    retry_d = retry_q;

    case (state_q)
      IDLE: begin
        if (play && done) begin
          idx_d   = '0;
          retry_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (rom_q.long == END_MARKER) begin
`ifdef SONG_LOOP_EN
          idx_d   = '0;
          state_d = LOAD;
`else
          state_d = IDLE;
`endif
        end else begin
          high_d  = rom_q.high;
          long_d  = rom_q.long;
          level_d = rom_q.level;
          retry_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ack_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // One retry of start if the driver never acknowledges by dropping done.
        if (!done) begin
          state_d = WAIT_DONE;
        end else if (ack_q == ACK_W'(ACK_WAIT - 1)) begin
          if (retry_q) begin
            state_d = IDLE;
          end else begin
            retry_d = 1'b1;
            state_d = ISSUE;
          end
        end else begin
          ack_d = ACK_W'(ack_q + ACK_W'(1));
        end
      end
      WAIT_DONE: begin
        if (done) state_d = GAP;
      end
      GAP: begin
        presc_d = presc_q;
        gap_d   = gap_q;
        if (presc_q == PRE_W'(CLK_FRE - 1)) begin
          presc_d = '0;
          if (gap_q == GAP_W'(GAP_US - 1)) begin
            gap_d = '0;
            if (note_idx == IDX_W'(SONG_LEN - 1)) begin
`ifdef SONG_LOOP_EN
              idx_d   = '0;
              state_d = LOAD;
`else
              state_d = IDLE;
`endif
            end else begin
              idx_d   = IDX_W'(note_idx + IDX_W'(1));
              state_d = LOAD;
            end
          end else begin
            gap_d = GAP_W'(gap_q + GAP_W'(1));
          end
        end else begin
          presc_d = PRE_W'(presc_q + PRE_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) state_d = IDLE;

    start_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with a small note-driver model; define SONG_LOOP_EN for the loop scenario.
module tb_beep_sequencer;

  localparam int G = 2000;  // gap length in clocks: 2 MHz * 1 ms

  logic       clk = 1'b0;
  logic       rst, play, stop, done;
  logic       start, busy;
  logic [3:0] high, long, level;
  logic [4:0] note_idx;

  int n_pass  = 0;
  int n_total = 0;
  bit drv_en  = 1'b0;

  beep_sequencer #(.CLK_FRE(2), .GAP_MS(1), .SONG_LEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .play     (play),
    .stop     (stop),
    .done     (done),
    .start    (start),
    .high     (high),
    .long     (long),
    .level    (level),
    .busy     (busy),
    .note_idx (note_idx)
  );

  always #5 clk = ~clk;

  // Note driver model: drops done after seeing start, holds it low 100 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (drv_en && start) begin
        done = 1'b0;
        repeat (100) @(negedge clk);
        done = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic wait_start(input int limit, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < limit && !seen) begin
      @(negedge clk);
      cyc++;
      if (start) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input int limit, output int cyc, output int starts);
    cyc    = 0;
    starts = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (start) starts++;
    end while (busy && cyc < limit);
  endtask

  task automatic pulse_play();
    @(negedge clk) play = 1'b1;
    @(negedge clk) play = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; play = 1'b0; stop = 1'b0; done = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({start, busy, high, long, level, note_idx} !== {1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 5'd0})
      $display("FAIL reset_values: got %b expected %b",
               {start, busy, high, long, level, note_idx}, {1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 5'd0});
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_play_ignored();
    int  cyc;
    bit  seen;
    drv_en = 1'b0;
    done   = 1'b0;
    pulse_play();
    wait_start(6, cyc, seen);
    n_total++;
    if (seen !== 1'b0) $display("FAIL play_no_done_start: got %0b expected 0", seen);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL play_no_done_busy: got %0b expected 0", busy);
    else n_pass++;
    done = 1'b1;
    @(negedge clk) begin play = 1'b1; stop = 1'b1; end
    @(negedge clk) begin play = 1'b0; stop = 1'b0; end
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL stop_over_play_busy: got %0b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_song();
    int cyc, starts;
    bit seen;
    drv_en = 1'b1;
    pulse_play();
    wait_start(10, cyc, seen);
    n_total++;
    if (!seen || cyc != 1) $display("FAIL song_first_start: got seen=%0b cyc=%0d expected seen=1 cyc=1", seen, cyc);
    else n_pass++;
    n_total++;
    if ({high, long, level, note_idx} !== {4'd5, 4'd4, 4'd1, 5'd0})
      $display("FAIL song_note0_fields: got %h expected %h", {high, long, level, note_idx}, {4'd5, 4'd4, 4'd1, 5'd0});
    else n_pass++;
    wait_start(5000, cyc, seen);
    n_total++;
    if (!seen || cyc != G + 102)
      $display("FAIL song_start_interval: got seen=%0b cyc=%0d expected seen=1 cyc=%0d", seen, cyc, G + 102);
    else n_pass++;
    n_total++;
    if ({high, long, level, note_idx} !== {4'd3, 4'd4, 4'd1, 5'd1})
      $display("FAIL song_note1_fields: got %h expected %h", {high, long, level, note_idx}, {4'd3, 4'd4, 4'd1, 5'd1});
    else n_pass++;
    wait_idle(5000, cyc, starts);
    n_total++;
    if (cyc != G + 102) $display("FAIL song_busy_fall: got %0d cycles expected %0d", cyc, G + 102);
    else n_pass++;
    n_total++;
    if (starts != 0) $display("FAIL song_extra_start: got %0d expected 0", starts);
    else n_pass++;
    n_total++;
    if (note_idx !== 5'd2) $display("FAIL song_end_idx: got %0d expected 2", note_idx);
    else n_pass++;
  endtask

  task automatic test_stop();
    int cyc;
    bit seen;
    drv_en = 1'b1;
    pulse_play();
    wait_start(10, cyc, seen);
    n_total++;
    if (!seen) $display("FAIL stop_first_start: got 0 expected 1");
    else n_pass++;
    repeat (10) @(negedge clk);
    pulse_stop();
    n_total++;
    if ({busy, start} !== 2'b00) $display("FAIL stop_next_edge: got busy,start=%b expected 00", {busy, start});
    else n_pass++;
    wait_start(2500, cyc, seen);
    n_total++;
    if (seen !== 1'b0) $display("FAIL stop_no_more_start: got %0b expected 0", seen);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL stop_busy_after: got %0b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_retry();
    int cyc, starts;
    bit seen;
    drv_en = 1'b0;
    done   = 1'b1;
    pulse_play();
    wait_start(10, cyc, seen);
    n_total++;
    if (!seen || cyc != 1) $display("FAIL retry_first_start: got seen=%0b cyc=%0d expected seen=1 cyc=1", seen, cyc);
    else n_pass++;
    wait_start(20, cyc, seen);
    n_total++;
    if (!seen || cyc != 4) $display("FAIL retry_interval: got seen=%0b cyc=%0d expected seen=1 cyc=4", seen, cyc);
    else n_pass++;
    wait_idle(50, cyc, starts);
    n_total++;
    if (cyc != 4 || starts != 0)
      $display("FAIL retry_give_up: got cyc=%0d starts=%0d expected cyc=4 starts=0", cyc, starts);
    else n_pass++;
  endtask

  task automatic test_reset_in_gap();
    int cyc;
    bit seen;
    drv_en = 1'b1;
    pulse_play();
    wait_start(10, cyc, seen);
    repeat (150) @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if ({start, busy, high, long, level, note_idx} !== {1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 5'd0})
      $display("FAIL gap_reset_values: got %b expected %b",
               {start, busy, high, long, level, note_idx}, {1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 5'd0});
    else n_pass++;
    @(negedge clk) rst = 1'b0;
    pulse_play();
    wait_start(10, cyc, seen);
    n_total++;
    if (!seen || cyc != 1) $display("FAIL gap_restart_start: got seen=%0b cyc=%0d expected seen=1 cyc=1", seen, cyc);
    else n_pass++;
    n_total++;
    if ({high, long, level, note_idx} !== {4'd5, 4'd4, 4'd1, 5'd0})
      $display("FAIL gap_restart_fields: got %h expected %h", {high, long, level, note_idx}, {4'd5, 4'd4, 4'd1, 5'd0});
    else n_pass++;
    pulse_stop();
    n_total++;
    if (busy !== 1'b0) $display("FAIL gap_restart_stop: got %0b expected 0", busy);
    else n_pass++;
    repeat (120) @(negedge clk);
  endtask

`ifdef SONG_LOOP_EN
  task automatic test_loop();
    int cyc;
    bit seen;
    drv_en = 1'b1;
    pulse_play();
    for (int k = 0; k < 4; k++) begin
      wait_start(5000, cyc, seen);
      n_total++;
      if (!seen || note_idx !== 5'(k % 2))
        $display("FAIL loop_idx_%0d: got seen=%0b idx=%0d expected seen=1 idx=%0d", k, seen, note_idx, k % 2);
      else n_pass++;
    end
    pulse_stop();
    n_total++;
    if (busy !== 1'b0) $display("FAIL loop_stop_busy: got %0b expected 0", busy);
    else n_pass++;
    repeat (120) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_play_ignored();
    test_song();
    test_stop();
    repeat (20) @(negedge clk);
    test_retry();
    test_reset_in_gap();
`ifdef SONG_LOOP_EN
    test_loop();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
